// File: rtl/rgb_status_sequencer.sv
// Status RGB LED sequencer: turn colour, win/tie flash bursts and solid hold.
// Optional duty fading is compiled in by defining RGB_STATUS_FADE_EN.
module rgb_status_sequencer #(
   parameter int R           = 8,
   parameter int TICK_DIV    = 1_000_000,
   parameter int BLINK_TICKS = 25,
   parameter int FLASH_COUNT = 3,
   parameter int FADE_STEP   = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   win_state,
   input  logic [3:0]   tie_state,
   input  logic [1:0]   player_sel,
   input  logic         new_game,
   output logic [R:0]   red_duty,
   output logic [R:0]   green_duty,
   output logic [R:0]   blue_duty,
   output logic         busy,
   output logic [2:0]   fsm_state_dbg
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int PW = $clog2(FLASH_COUNT + 1);

   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [PW-1:0] FLASH_LAST = PW'(FLASH_COUNT);
   localparam logic [R:0]    FULL       = (R+1)'((1 << R) - 1);
   localparam logic [R:0]    ZERO       = '0;

   generate
      if (TICK_DIV < 2 || BLINK_TICKS < 1 || FLASH_COUNT < 1 || FADE_STEP < 1) begin : g_bad_cfg
         $error("rgb_status_sequencer: illegal parameter set");
      end
   endgenerate

   // Debug encoding: TURN=0, WIN_FLASH=1, TIE_FLASH=2, WIN_HOLD=3, TIE_HOLD=4.
   typedef enum logic [2:0] {
      S_TURN      = 3'd0,
      S_WIN_FLASH = 3'd1,
      S_TIE_FLASH = 3'd2,
      S_WIN_HOLD  = 3'd3,
      S_TIE_HOLD  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic [PW-1:0] on_cnt_q, on_cnt_d;
   logic          on_q, on_d;
   logic [R:0]    red_q, green_q, blue_q;
   logic [R:0]    red_d, green_d, blue_d;
   logic [R:0]    tgt_r, tgt_g, tgt_b;
   logic          busy_q, busy_d;

   logic flashing, tick, phase_end, burst_done, entry;

   assign flashing   = (state_q == S_WIN_FLASH) || (state_q == S_TIE_FLASH);
   assign tick       = (tick_cnt_q == TICK_LAST);
   assign phase_end  = flashing && tick && (blink_cnt_q == BLINK_LAST);
   assign burst_done = phase_end && !on_q && (on_cnt_q == FLASH_LAST);
   // Re-entering TURN through new_game also counts as an entry so timing restarts.
   assign entry      = (state_d != state_q) || new_game;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_TURN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_TURN: begin
            if (win_state != 4'd0) begin
               state_d = S_WIN_FLASH;
            end else if (tie_state != 4'd0) begin
               state_d = S_TIE_FLASH;
            end
         end
         S_WIN_FLASH: if (burst_done) state_d = S_WIN_HOLD;
         S_TIE_FLASH: if (burst_done) state_d = S_TIE_HOLD;
         default: state_d = state_q;
      endcase
      if (new_game) begin
         state_d = S_TURN;
      end
   end

   always_comb begin
      tick_cnt_d  = tick_cnt_q + 1'b1;
      blink_cnt_d = blink_cnt_q;
      on_cnt_d    = on_cnt_q;
      on_d        = on_q;
      if (entry) begin
         tick_cnt_d  = '0;
         blink_cnt_d = '0;
         on_cnt_d    = '0;
         on_d        = 1'b1;
      end else begin
         if (tick) begin
            tick_cnt_d = '0;
         end
         if (!flashing) begin
            blink_cnt_d = '0;
         end else if (tick) begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
         end
         if (phase_end) begin
            on_d = !on_q;
            if (on_q) begin
               on_cnt_d = on_cnt_q + 1'b1;
            end
         end
      end
   end

`ifdef RGB_STATUS_FADE_EN
   function automatic logic [R:0] fade_toward(input logic [R:0] cur, input logic [R:0] tgt);
      logic [R+1:0] c, t, s, d;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      s = (R+2)'(FADE_STEP);
      d = '0;
      fade_toward = cur;
      if (c < t) begin
         d = c + s;
         fade_toward = (t - c <= s) ? tgt : d[R:0];
      end else if (c > t) begin
         d = c - s;
         fade_toward = (c - t <= s) ? tgt : d[R:0];
      end
   endfunction
`endif

   // Targets come from the next state so colour and busy change on the same edge as the state.
   always_comb begin
      tgt_r = ZERO;
      tgt_g = ZERO;
      tgt_b = ZERO;
      case (state_d)
         S_TURN: begin
            if (player_sel == 2'd1) tgt_b = FULL;
            if (player_sel == 2'd2) tgt_r = FULL;
         end
         S_WIN_FLASH: if (on_d) tgt_g = FULL;
         S_TIE_FLASH: begin
            if (on_d) begin
               tgt_r = FULL;
               tgt_g = FULL;
            end
         end
         S_WIN_HOLD: tgt_g = FULL;
         S_TIE_HOLD: begin
            tgt_r = FULL;
            tgt_g = FULL;
         end
         default: tgt_r = ZERO;
      endcase
      busy_d = (state_d == S_WIN_FLASH) || (state_d == S_TIE_FLASH);
`ifdef RGB_STATUS_FADE_EN
      red_d   = tick ? fade_toward(red_q, tgt_r)   : red_q;
      green_d = tick ? fade_toward(green_q, tgt_g) : green_q;
      blue_d  = tick ? fade_toward(blue_q, tgt_b)  : blue_q;
`else
      red_d   = tgt_r;
      green_d = tgt_g;
      blue_d  = tgt_b;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q  <= '0;
         blink_cnt_q <= '0;
         on_cnt_q    <= '0;
         on_q        <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         on_cnt_q    <= on_cnt_d;
         on_q        <= on_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         busy_q      <= busy_d;
      end
   end

   assign red_duty      = red_q;
   assign green_duty    = green_q;
   assign blue_duty     = blue_q;
   assign busy          = busy_q;
   assign fsm_state_dbg = state_q;

endmodule
